// File: rtl/multicycle_control.sv
// multicycle_control: multicycle RV32I-subset control FSM; build option ILLEGAL_TRAP_EN selects trap vs NOP on illegal instructions.
// Latency (zero-wait memory): R/I/store 4, load 5, branch/JAL/LUI 3 cycles; each memory wait cycle adds one.
// Backpressure: memory request held in FETCH/MEM_RD/MEM_WR until iMemReady; only oIRWrite/oPCWrite see iMemReady combinationally.
module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [6:0]           iOpcode,
  input  logic [2:0]           iFunct3,
  input  logic                 iFunct7b5,
  input  logic                 iZero,
  input  logic                 iMemReady,
  output logic                 oMemReq,
  output logic                 oMemWrite,
  output logic                 oIorD,
  output logic                 oIRWrite,
  output logic                 oPCWrite,
  output logic                 oRegWrite,
  output logic [3:0]           oALUControl,
  output logic [1:0]           oALUSrcA,
  output logic [1:0]           oALUSrcB,
  output logic [1:0]           oResultSrc,
  output logic                 oIllegal,
  output logic [INSTRET_W-1:0] oInstret
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_FWD = 4'b1000;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  state_t                w_nx_state;
  state_t                w_ill_tgt;
  logic                  w_retire;
  logic                  w_f3_alu_ok;
  logic                  w_f3_br_ok;
  logic                  w_br_take;
  logic [3:0]            w_alu_dec;
  logic [INSTRET_W-1:0]  r_instret;

  // Datapath controls decoded from the state being entered, so they come out of flops.
  logic                  w_memreq, w_memwrite, w_iord, w_regwrite;
  logic [3:0]            w_alu;
  logic [1:0]            w_srca, w_srcb, w_rs;
  logic                  r_memreq, r_memwrite, r_iord, r_regwrite;
  logic [3:0]            r_alu;
  logic [1:0]            r_srca, r_srcb, r_rs;

`ifdef ILLEGAL_TRAP_EN
  assign w_ill_tgt = S_TRAP;
`else
  assign w_ill_tgt = S_FETCH;
`endif

  assign w_f3_alu_ok = (iFunct3 == 3'b000) || (iFunct3 == 3'b010) ||
                       (iFunct3 == 3'b110) || (iFunct3 == 3'b111);
  assign w_f3_br_ok  = (iFunct3[2:1] == 2'b00);
  assign w_br_take   = (iFunct3 == 3'b000) ? iZero : ((iFunct3 == 3'b001) && !iZero);
  assign w_nx_state  = iRST_N ? w_next : S_FETCH;

  // ALU op for R/I execute; funct7b5 selects SUB only for register-register ops.
  always_comb begin
    w_alu_dec = ALU_ADD;
    case (iFunct3)
      3'b000:  w_alu_dec = (iOpcode == OP_R && iFunct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_dec = ALU_SLT;
      3'b110:  w_alu_dec = ALU_OR;
      3'b111:  w_alu_dec = ALU_AND;
      default: w_alu_dec = ALU_ADD;
    endcase
  end

  // Next state and retire strobe; illegal paths retire nothing.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  w_next = iMemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (iOpcode)
          OP_R:             w_next = S_EXEC_R;
          OP_I:             w_next = S_EXEC_I;
          OP_LOAD, OP_STORE: w_next = S_ADDR;
          OP_BR:            w_next = S_BRANCH;
          OP_JAL:           w_next = S_JAL;
          OP_LUI:           w_next = S_LUI;
          default:          w_next = w_ill_tgt;
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = w_f3_alu_ok ? S_WB_ALU : w_ill_tgt;
      S_ADDR:   w_next = (iOpcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: w_next = iMemReady ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: begin
        w_next   = iMemReady ? S_FETCH : S_MEM_WR;
        w_retire = iMemReady;
      end
      S_BRANCH: begin
        w_next   = w_f3_br_ok ? S_FETCH : w_ill_tgt;
        w_retire = w_f3_br_ok;
      end
      S_WB_ALU, S_WB_MEM, S_JAL, S_LUI: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Control word for the state about to be entered.
  always_comb begin
    w_memreq   = 1'b0;
    w_memwrite = 1'b0;
    w_iord     = 1'b0;
    w_regwrite = 1'b0;
    w_alu      = ALU_ADD;
    w_srca     = 2'd0;
    w_srcb     = 2'd0;
    w_rs       = 2'd0;
    case (w_nx_state)
      S_FETCH:  begin w_memreq = 1'b1; w_srcb = 2'd2; end
      S_DECODE: begin w_srca = 2'd1; w_srcb = 2'd1; end
      S_EXEC_R: begin w_srca = 2'd2; w_srcb = 2'd0; w_alu = w_alu_dec; end
      S_EXEC_I: begin w_srca = 2'd2; w_srcb = 2'd1; w_alu = w_alu_dec; end
      S_ADDR:   begin w_srca = 2'd2; w_srcb = 2'd1; end
      S_MEM_RD: begin w_memreq = 1'b1; w_iord = 1'b1; end
      S_MEM_WR: begin w_memreq = 1'b1; w_iord = 1'b1; w_memwrite = 1'b1; end
      S_WB_ALU: begin w_regwrite = 1'b1; w_rs = 2'd0; end
      S_WB_MEM: begin w_regwrite = 1'b1; w_rs = 2'd1; end
      S_BRANCH: begin w_srca = 2'd2; w_srcb = 2'd0; w_alu = ALU_SUB; end
      S_JAL:    begin w_srca = 2'd1; w_srcb = 2'd2; w_rs = 2'd2; w_regwrite = 1'b1; end
      S_LUI:    begin w_srcb = 2'd1; w_alu = ALU_FWD; w_rs = 2'd2; w_regwrite = 1'b1; end
      default:  begin w_alu = ALU_AND; end
    endcase
  end

  // State and retired-instruction counter; reset abandons any instruction in flight.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  // Register the decoded control word alongside the state.
  always_ff @(posedge iCLK) begin
    r_memreq   <= w_memreq;
    r_memwrite <= w_memwrite;
    r_iord     <= w_iord;
    r_regwrite <= w_regwrite;
    r_alu      <= w_alu;
    r_srca     <= w_srca;
    r_srcb     <= w_srcb;
    r_rs       <= w_rs;
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  // Sticky illegal flag, set on entry to TRAP and cleared only by reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_N)               r_illegal <= 1'b0;
    else if (w_next == S_TRAP) r_illegal <= 1'b1;
  end
  assign oIllegal = iRST_N & r_illegal;
`else
  assign oIllegal = 1'b0;
`endif

  assign oMemReq     = iRST_N & r_memreq;
  assign oMemWrite   = iRST_N & r_memwrite;
  assign oIorD       = iRST_N & r_iord;
  assign oRegWrite   = iRST_N & r_regwrite;
  assign oALUControl = iRST_N ? r_alu  : 4'd0;
  assign oALUSrcA    = iRST_N ? r_srca : 2'd0;
  assign oALUSrcB    = iRST_N ? r_srcb : 2'd0;
  assign oResultSrc  = iRST_N ? r_rs   : 2'd0;
  assign oInstret    = iRST_N ? r_instret : '0;
  assign oIRWrite    = iRST_N & (r_state == S_FETCH) & iMemReady;
  assign oPCWrite    = iRST_N & (((r_state == S_FETCH) & iMemReady) |
                                 (r_state == S_JAL) |
                                 ((r_state == S_BRANCH) & w_br_take));

endmodule
